// File: rtl/fifo_out_stage_pkg.sv
// Shared defaults and occupancy encoding for the FIFO output stage.
package fifo_out_stage_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry in-order holding buffer (head/tail); a load lands one cycle after load_i.
// Head is presented registered; take_i pops it and the tail moves up.
module fifo_out_skid
    import fifo_out_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_dat_i,
    input  logic                  take_i,
    output occ_t                  count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    occ_t                  count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clr_i) begin
            count_d = OCC_EMPTY;
        end else begin
            case ({load_i, take_i})
                2'b10: begin
                    if (count_q == OCC_EMPTY) head_d = load_dat_i;
                    else                      tail_d = load_dat_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Simultaneous load and pop keeps occupancy; the new word joins behind what remains.
                2'b11: begin
                    if (count_q == OCC_ONE) begin
                        head_d = load_dat_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = load_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fifo_out_stage.sv
// FIFO-to-stream output stage: pops FIFO into a 2-deep buffer, 1-cycle pop-to-data, sink stall stops pops at 2.
// Beat counter is built only when FIFO_OUT_STAGE_BEAT_CNT_EN is defined; otherwise m_beat_cnt reads 0.
module fifo_out_stage
    import fifo_out_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  m_beat_cnt
);

    occ_t count;
    logic xfer;

    // Pop decision depends only on local occupancy, never on m_ready.
    assign fifo_rd_en = !fifo_empty && (count < OCC_FULL) && !flush && !reset;
    assign m_valid    = (count != OCC_EMPTY);
    assign xfer       = m_valid && m_ready && !flush;

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i      (clk),
        .reset_i    (reset),
        .clr_i      (flush),
        .load_i     (fifo_rd_en),
        .load_dat_i (fifo_dout),
        .take_i     (xfer),
        .count_o    (count),
        .head_o     (m_data)
    );

`ifdef FIFO_OUT_STAGE_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     beat_cnt_q <= '0;
        else if (xfer) beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
    end

    assign m_beat_cnt = beat_cnt_q;
`else
    assign m_beat_cnt = '0;
`endif

endmodule
